// File: rtl/decoded_inst_queue.sv
// Dual-lane in-order queue between decode and issue. Holds a branch back from
// issue until its delay slot is also queued.
package decoded_inst_queue_pkg;
  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_br_op;
    logic       is_mem_op;
  } decoded_inst_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exception_t;
endpackage

module decoded_inst_queue_chk (
  input logic       clk,
  input logic       reset,
  input logic       flush,
  input logic [1:0] out_valid,
  input logic [1:0] issue_cnt
);
  // issue may never take more entries than are presented
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert ({1'b0, issue_cnt} <= ({2'b00, out_valid[0]} + {2'b00, out_valid[1]}));
    end
  end
endmodule

module decoded_inst_queue
  import decoded_inst_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  input  virt_t         [1:0] in_pc,
  input  decoded_inst_t [1:0] in_inst,
  input  exception_t    [1:0] in_ex,
  output logic                in_ready,
  output logic [1:0]          out_valid,
  output virt_t         [1:0] out_pc,
  output decoded_inst_t [1:0] out_inst,
  output exception_t    [1:0] out_ex,
  input  logic [1:0]          issue_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    virt_t         pc;
    decoded_inst_t inst;
    exception_t    ex;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head1;
  logic [PW-1:0] tail1;
  logic [CW-1:0] count;
  logic [CW-1:0] space;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [1:0]    avail;
  logic          push_en;
  logic          br0;
  logic          br1;

  assign head1    = head + PW'(1);
  assign tail1    = tail + PW'(in_valid[0]);
  assign space    = CW'(DEPTH) - count;
  assign in_ready = (space >= CW'(2));
  assign push_en  = in_ready && !flush && !reset;
  assign push_n   = push_en ? (2'(in_valid[0]) + 2'(in_valid[1])) : 2'd0;
  assign br0      = mem[head].inst.is_br_op;
  assign br1      = mem[head1].inst.is_br_op;
  assign avail    = 2'(out_valid[0]) + 2'(out_valid[1]);
  assign pop_n    = (issue_cnt > avail) ? avail : issue_cnt;

  // head window presented to issue, with delay-slot gating
  always_comb begin
    out_pc[0]   = mem[head].pc;
    out_pc[1]   = mem[head1].pc;
    out_inst[0] = mem[head].inst;
    out_inst[1] = mem[head1].inst;
    out_ex[0]   = mem[head].ex;
    out_ex[1]   = mem[head1].ex;
    if (count == CW'(0)) begin
      out_valid = 2'b00;
    end else if (br0 && (count == CW'(1))) begin
      out_valid = 2'b00;
    end else if (br1 && (count == CW'(2))) begin
      out_valid = 2'b01;
    end else begin
      out_valid = {(count >= CW'(2)), 1'b1};
    end
  end

  // pointers and occupancy; flush and reset drop everything including this cycle's push
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // compacting write: valid lanes land at tail, tail+1 in lane order
  always_ff @(posedge clk) begin
    if (push_en && in_valid[0]) begin
      mem[tail] <= '{pc: in_pc[0], inst: in_inst[0], ex: in_ex[0]};
    end
    if (push_en && in_valid[1]) begin
      mem[tail1] <= '{pc: in_pc[1], inst: in_inst[1], ex: in_ex[1]};
    end
  end

  decoded_inst_queue_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .out_valid (out_valid),
    .issue_cnt (issue_cnt)
  );
endmodule

// File: tb/tb_decoded_inst_queue.sv
// Self-checking bench: a queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_decoded_inst_queue;
  import decoded_inst_queue_pkg::*;

  localparam int DEPTH = 16;

  typedef struct packed {
    virt_t         pc;
    decoded_inst_t inst;
    exception_t    ex;
  } ent_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic [1:0]          in_valid = 2'b00;
  virt_t         [1:0] in_pc;
  decoded_inst_t [1:0] in_inst;
  exception_t    [1:0] in_ex;
  logic                in_ready;
  logic [1:0]          out_valid;
  virt_t         [1:0] out_pc;
  decoded_inst_t [1:0] out_inst;
  exception_t    [1:0] out_ex;
  logic [1:0]          issue_cnt = 2'b00;

  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  ent_t mq[$];
  virt_t issued[$];
  bit   rec = 1'b0;

  decoded_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_inst(in_inst), .in_ex(in_ex), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ex(out_ex), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    else pass_cnt++;
  endtask

  function automatic ent_t mk(input virt_t p, input logic b);
    ent_t e;
    e.pc   = p;
    e.inst = '{op: p[7:2], rs: p[6:2], rt: 5'd0, rd: p[11:7], is_br_op: b, is_mem_op: 1'b0};
    e.ex   = '{valid: p[2], code: p[8:4]};
    return e;
  endfunction

  // what issue may see, from queue contents alone
  function automatic logic [1:0] exp_valid();
    int n = mq.size();
    if (n == 0) return 2'b00;
    if (n == 1) return mq[0].inst.is_br_op ? 2'b00 : 2'b01;
    if (n == 2 && mq[1].inst.is_br_op) return 2'b01;
    return 2'b11;
  endfunction

  // one cycle: compare DUT to model, drive inputs, advance model at the edge
  task automatic step(input logic rs, input logic fl, input logic [1:0] v,
                      input virt_t p0, input virt_t p1, input logic b0, input logic b1,
                      input int ic);
    logic [1:0] ev;
    logic       er;
    int         n_pop;
    ent_t       e0;
    ent_t       e1;
    ev = exp_valid();
    er = (DEPTH - mq.size()) >= 2;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int l = 0; l < 2; l++) begin
      if (ev[l]) begin
        chk("out_pc", 64'(out_pc[l]), 64'(mq[l].pc));
        chk("out_inst", 64'(out_inst[l]), 64'(mq[l].inst));
        chk("out_ex", 64'(out_ex[l]), 64'(mq[l].ex));
      end
    end
    n_pop = ic;
    if (n_pop > int'(ev[0]) + int'(ev[1])) n_pop = int'(ev[0]) + int'(ev[1]);
    if (rec && !rs && !fl) begin
      for (int l = 0; l < n_pop; l++) issued.push_back(out_pc[l]);
    end
    e0 = mk(p0, b0);
    e1 = mk(p1, b1);
    reset = rs; flush = fl; in_valid = v;
    in_pc[0] = e0.pc; in_inst[0] = e0.inst; in_ex[0] = e0.ex;
    in_pc[1] = e1.pc; in_inst[1] = e1.inst; in_ex[1] = e1.ex;
    issue_cnt = 2'(n_pop);
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      repeat (n_pop) void'(mq.pop_front());
      if (er && v[0]) mq.push_back(e0);
      if (er && v[1]) mq.push_back(e1);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2);
  endtask

  initial begin
    int    n;
    int    cyc;
    logic  [1:0] v;
    virt_t p0;
    virt_t p1;
    bit    rdy;
    in_pc = '0; in_inst = '0; in_ex = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'(2'b00));
    chk("rst_ready", 64'(in_ready), 64'(1'b1));

    // 1: basic pair, issue both
    step(1'b0, 1'b0, 2'b11, 32'hbfc00000, 32'hbfc00004, 1'b0, 1'b0, 0);
    chk("t1_valid", 64'(out_valid), 64'(2'b11));
    chk("t1_pc0", 64'(out_pc[0]), 64'(32'hbfc00000));
    chk("t1_pc1", 64'(out_pc[1]), 64'(32'hbfc00004));
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2);
    chk("t1_empty", 64'(out_valid), 64'(2'b00));

    // 2: fill to DEPTH, extra push ignored
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i), 1'b0, 1'b0, 0);
    chk("t2_ready14", 64'(in_ready), 64'(1'b1));
    step(1'b0, 1'b0, 2'b11, 32'h1038, 32'h103c, 1'b0, 1'b0, 0);
    chk("t2_ready16", 64'(in_ready), 64'(1'b0));
    step(1'b0, 1'b0, 2'b11, 32'hdead0000, 32'hdead0004, 1'b0, 1'b0, 0);
    chk("t2_full_ready", 64'(in_ready), 64'(1'b0));
    chk("t2_head_pc", 64'(out_pc[0]), 64'(32'h1000));
    drain();

    // 3: lone branch held until its slot arrives
    step(1'b0, 1'b0, 2'b01, 32'h2000, 32'h0, 1'b1, 1'b0, 0);
    chk("t3_lone_br", 64'(out_valid), 64'(2'b00));
    step(1'b0, 1'b0, 2'b01, 32'h2004, 32'h0, 1'b0, 1'b0, 0);
    chk("t3_with_slot", 64'(out_valid), 64'(2'b11));
    chk("t3_br_lane0", 64'(out_pc[0]), 64'(32'h2000));
    drain();

    // 4: [ALU, BR] then slot
    step(1'b0, 1'b0, 2'b11, 32'h3000, 32'h3004, 1'b0, 1'b1, 0);
    chk("t4_alu_br", 64'(out_valid), 64'(2'b01));
    step(1'b0, 1'b0, 2'b01, 32'h3008, 32'h0, 1'b0, 1'b0, 1);
    chk("t4_valid", 64'(out_valid), 64'(2'b11));
    chk("t4_pc0", 64'(out_pc[0]), 64'(32'h3004));
    chk("t4_pc1", 64'(out_pc[1]), 64'(32'h3008));
    drain();

    // 5: flush beats push and pop; reset mid-operation acts the same
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 2'b11, 32'h4000 + 32'(8 * i), 32'h4004 + 32'(8 * i), 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 2'b11, 32'h5000, 32'h5004, 1'b0, 1'b0, 2);
    chk("t5_valid", 64'(out_valid), 64'(2'b00));
    chk("t5_ready", 64'(in_ready), 64'(1'b1));
    step(1'b0, 1'b0, 2'b11, 32'h6000, 32'h6004, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 2'b11, 32'h6008, 32'h600c, 1'b0, 1'b0, 1);
    chk("t5_rst_valid", 64'(out_valid), 64'(2'b00));

    // 6: stream 40 pcs with stalls, issue alternating 1/2
    rec = 1'b1;
    n = 0;
    cyc = 0;
    while (issued.size() < 40 && cyc < 400) begin
      v = 2'($urandom_range(0, 3));
      if (n >= 40) v = 2'b00;
      else if (n == 39 && v == 2'b11) v = 2'b01;
      p0 = 32'h8000_0000 + 32'(4 * n);
      p1 = (v == 2'b11) ? p0 + 32'd4 : p0;
      rdy = (DEPTH - mq.size()) >= 2;
      step(1'b0, 1'b0, v, p0, p1, 1'b0, 1'b0, (cyc % 2 == 1) ? 2 : 1);
      if (rdy) n += int'(v[0]) + int'(v[1]);
      cyc++;
    end
    chk("t6_count", 64'(issued.size()), 64'(40));
    for (int i = 0; i < issued.size() && i < 40; i++)
      chk("t6_order", 64'(issued[i]), 64'(32'h8000_0000 + 32'(4 * i)));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
